mc_result_capture: RTL and testbench
====================================

// Module: mc_result_capture
// PURPOSE
//  Downstream consumer of the multicycle pll->div crossing stage, in the div_clock domain.
//  Records DEPTH consecutive samples of the crossed result word into an on-chip buffer once armed and triggered.
//  Exposes control, status and buffered data to the HPS through an Avalon-MM slave with fixed read latency 1.
// PARAMETERS
//  WIDTH   32  width of captured data word (1..32); zero-extended on readdata
//  DEPTH   256 buffer entries; power of two, 2..1024
//  AW      8   log2(DEPTH); sizes count and pointers
// PORTS
//  div_clock        in   1      single clock (divided clock domain)
//  reset_n          in   1      synchronous reset, active-low
//  data_in          in   WIDTH  crossed result word, new value each div_clock
//  trigger          in   1      one-cycle start pulse from stimulus logic, same domain
//  avs_address      in   2      word address: 0 CTRL/STAT, 1 COUNT, 2 RD_PTR, 3 DATA
//  avs_read         in   1      read strobe
//  avs_write        in   1      write strobe
//  avs_writedata    in   32     write data
//  avs_readdata     out  32     read data, valid cycle after avs_read
//  busy             out  1      high in ARMED or CAPTURE
//  done             out  1      high in DONE
// BEHAVIOUR
//  Reset (reset_n low at a div_clock edge): state IDLE, count=0, rd_ptr=0, avs_readdata=0, busy=0, done=0.
//   Reset mid-capture aborts immediately; buffer contents undefined, not cleared.
//  FSM: IDLE -(write CTRL bit0=1)-> ARMED -(trigger)-> CAPTURE -(count reaches DEPTH)-> DONE.
//   DONE -(write CTRL bit0=1)-> ARMED (re-arm; count and rd_ptr reset to 0 on arm).
//   Write CTRL bit1=1 (clear) from any state -> IDLE, count=0, rd_ptr=0; clear wins over arm same write.
//   Arm while ARMED or CAPTURE: ignored. trigger outside ARMED: ignored.
//  Capture: the cycle trigger is seen in ARMED, data_in of that cycle is written to entry 0; each
//   following cycle writes entry count, count increments; after entry DEPTH-1 written, state DONE,
//   count==DEPTH (count is AW+1 bits). No gaps, no skipped samples.
//  Register reads (returned in avs_readdata one cycle after avs_read; otherwise holds last value):
//   0 CTRL/STAT: bit0 busy, bit1 done, bits[3:2] state code, rest 0.
//   1 COUNT: count, zero-extended.
//   2 RD_PTR: rd_ptr, zero-extended.
//   3 DATA: buffer[rd_ptr] zero-extended; rd_ptr increments modulo DEPTH after the read.
//  RD_PTR write: rd_ptr <= writedata[AW-1:0]; upper bits ignored. Writes to 1 and 3: ignored.
//  DATA read while CAPTURE: allowed; returns current RAM contents (possibly from previous run).
//  Read and write same cycle: write applied; read returns pre-write register/pointer value.
//  Back-to-back DATA reads each cycle: each returns successive entries, no stalls (RAM read is 1 cycle).
//  Out-of-range entries (rd_ptr >= count): return stored RAM value, no error flag.
// STRUCTURE
//  Shared header mc_capture_defs.vh: register address localparams, CTRL bit positions, state codes
//   (IDLE=0, ARMED=1, CAPTURE=2, DONE=3).
//  Sub-module mc_capture_ram: simple dual-port RAM, write port (we, waddr, wdata), registered read port
//   (raddr, rdata), same clock; top holds FSM, counters and Avalon decode.
// TESTING
//  Reset then read addr 0 -> readdata 0x0; read addr 1 -> 0.
//  Arm, data_in=ramp 0,1,2..., trigger at ramp value 5, DEPTH=256 -> done after 256 cycles, COUNT=256,
//   DATA reads from rd_ptr 0 return 5,6,...,260.
//  Write RD_PTR=255 then two DATA reads -> entries 255 then 0 (wrap); RD_PTR reads 1.
//  Clear at capture cycle 100 -> state IDLE, COUNT=0, further trigger ignored until re-arm.
//  Write CTRL=0x3 while ARMED -> IDLE (clear wins); trigger before arm -> no capture, COUNT=0.
//  Assert reset_n low mid-capture at count 40 -> next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/mc_result_capture_pkg.sv
// Shared definitions for the result capture block: Avalon register map,
// control bit positions, FSM state codes and the status word layout.
package mc_result_capture_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_COUNT = 2'd1;
  localparam logic [1:0] ADDR_RDPTR = 2'd2;
  localparam logic [1:0] ADDR_DATA  = 2'd3;

  // CTRL write bits
  localparam int CTRL_ARM_BIT   = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  // State codes are visible to software through CTRL/STAT bits [3:2]
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // CTRL/STAT read word: bit0 busy, bit1 done, bits[3:2] state, rest zero
  function automatic logic [31:0] status_word(input cap_state_e st,
                                              input logic busy,
                                              input logic done);
    status_word = {28'd0, st, done, busy};
  endfunction

endpackage

// File: rtl/mc_capture_ram.sv
// Simple dual-port capture buffer: one write port and one registered read
// port on the same clock. The read register only updates when re is high,
// so the last read word is held for the bus.
module mc_capture_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: store one sample per enabled cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: one-cycle registered read, returns the pre-write contents
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mc_result_capture.sv
// Result capture block in the divided clock domain. Once armed by software
// and triggered by the stimulus logic it records DEPTH consecutive samples
// of data_in, then exposes status and the buffer over an Avalon-MM slave
// with fixed read latency 1.
module mc_result_capture
  import mc_result_capture_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             div_clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             trigger,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             busy,
  output logic             done
);

  // Index of the final buffer entry; count is one bit wider to reach DEPTH
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  cap_state_e       state_q, state_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      csr_rdata_q, csr_rdata_d;
  logic             rd_sel_data_q, rd_sel_data_d;

  logic             ctrl_wr_s;
  logic             clear_s;
  logic             arm_s;
  logic             ram_we_s;
  logic [AW-1:0]    ram_waddr_s;
  logic             ram_re_s;
  logic [WIDTH-1:0] ram_rdata_s;

  // Upper write-data bits have no destination
  logic             unused_wd_s;
  assign unused_wd_s = &{1'b0, avs_writedata[31:AW]};

  // Decode CTRL writes; clear takes priority over arm in the same write
  always_comb begin
    ctrl_wr_s = avs_write && (avs_address == ADDR_CTRL);
    clear_s   = ctrl_wr_s && avs_writedata[CTRL_CLEAR_BIT];
    arm_s     = ctrl_wr_s && avs_writedata[CTRL_ARM_BIT] && !clear_s;
    ram_re_s  = avs_read && (avs_address == ADDR_DATA);
  end

  // Capture FSM, sample counter and read pointer next-state logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    ram_we_s    = 1'b0;
    ram_waddr_s = count_q[AW-1:0];

    // Pointer side effects of bus traffic; RD_PTR write beats DATA read increment
    if (avs_write && (avs_address == ADDR_RDPTR)) begin
      rd_ptr_d = avs_writedata[AW-1:0];
    end else if (ram_re_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (arm_s) begin
          state_d  = ST_ARMED;
          count_d  = '0;
          rd_ptr_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (trigger) begin
          ram_we_s    = 1'b1;
          ram_waddr_s = '0;
          count_d     = (AW+1)'(1);
          state_d     = ST_CAPTURE;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = count_q[AW-1:0];
        count_d     = count_q + (AW+1)'(1);
        if (count_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (arm_s) begin
          state_d  = ST_ARMED;
          count_d  = '0;
          rd_ptr_d = '0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    // Clear aborts from any state and suppresses the sample write
    if (clear_s) begin
      state_d  = ST_IDLE;
      count_d  = '0;
      rd_ptr_d = '0;
      ram_we_s = 1'b0;
    end else begin
      ram_we_s = ram_we_s && reset_n;
    end
  end

  // Status outputs are registered from the next state
  always_comb begin
    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // Read response select; all register values are taken before this cycle's write
  always_comb begin
    csr_rdata_d   = csr_rdata_q;
    rd_sel_data_d = rd_sel_data_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_CTRL: begin
          csr_rdata_d   = status_word(state_q, busy_q, done_q);
          rd_sel_data_d = 1'b0;
        end
        ADDR_COUNT: begin
          csr_rdata_d   = 32'(count_q);
          rd_sel_data_d = 1'b0;
        end
        ADDR_RDPTR: begin
          csr_rdata_d   = 32'(rd_ptr_q);
          rd_sel_data_d = 1'b0;
        end
        ADDR_DATA: begin
          rd_sel_data_d = 1'b1;
        end
        default: begin
          rd_sel_data_d = 1'b0;
        end
      endcase
    end else begin
      rd_sel_data_d = rd_sel_data_q;
    end
  end

  // State, counters and read-path registers with synchronous active-low reset
  always_ff @(posedge div_clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      csr_rdata_q   <= 32'd0;
      rd_sel_data_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      csr_rdata_q   <= csr_rdata_d;
      rd_sel_data_q <= rd_sel_data_d;
    end
  end

  mc_capture_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (div_clock),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (data_in),
    .re    (ram_re_s),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata_s)
  );

  // DATA reads come straight from the RAM read register, others from the CSR register
  assign avs_readdata = rd_sel_data_q ? 32'(ram_rdata_s) : csr_rdata_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mc_result_capture.sv
// Self-checking bench for mc_result_capture: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of the capture block.
module tb_mc_result_capture;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;

  logic        div_clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        trigger = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        busy;
  logic        done;

  mc_result_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .div_clock     (div_clock),
    .reset_n       (reset_n),
    .data_in       (data_in),
    .trigger       (trigger),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .busy          (busy),
    .done          (done)
  );

  always #5 div_clock = ~div_clock;

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural model: 0 idle, 1 armed, 2 capturing, 3 done
  int          m_state = 0;
  int          m_count = 0;
  int          m_ptr = 0;
  logic [31:0] m_rd = 32'd0;
  bit          m_rd_known = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];

  logic [31:0] lit_exp_q [$];
  string       lit_name_q [$];
  int          ramp_v = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT is about to sample
  task automatic model_step();
    int  st0;
    int  new_ptr;
    bit  clr;
    bit  arm;
    if (!reset_n) begin
      m_state = 0; m_count = 0; m_ptr = 0;
      m_rd = 32'd0; m_rd_known = 1'b1; m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    st0 = m_state;
    new_ptr = m_ptr;
    clr = avs_write && (avs_address == 2'd0) && avs_writedata[1];
    arm = avs_write && (avs_address == 2'd0) && avs_writedata[0] && !clr;
    if (avs_read) begin
      case (avs_address)
        2'd0: begin
          m_rd = 32'(st0 * 4 + ((st0 == 3) ? 2 : 0) + ((st0 == 1 || st0 == 2) ? 1 : 0));
          m_rd_known = 1'b1;
        end
        2'd1: begin m_rd = 32'(m_count); m_rd_known = 1'b1; end
        2'd2: begin m_rd = 32'(m_ptr); m_rd_known = 1'b1; end
        default: begin
          m_rd = m_mem[m_ptr];
          m_rd_known = m_known[m_ptr];
          new_ptr = (m_ptr + 1) % DEPTH;
        end
      endcase
    end
    if (avs_write && avs_address == 2'd2) new_ptr = int'(avs_writedata % DEPTH);
    if (clr) begin
      m_state = 0; m_count = 0; new_ptr = 0;
    end else if (arm && (st0 == 0 || st0 == 3)) begin
      m_state = 1; m_count = 0; new_ptr = 0;
    end else if (st0 == 1 && trigger) begin
      m_mem[0] = data_in; m_known[0] = 1'b1; m_count = 1; m_state = 2;
    end else if (st0 == 2) begin
      m_mem[m_count] = data_in; m_known[m_count] = 1'b1;
      m_count++;
      if (m_count == DEPTH) m_state = 3;
    end
    m_ptr = new_ptr;
  endtask

  // Compare process: check outputs against the model, then step the model
  always @(negedge div_clock) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'((m_state == 1 || m_state == 2) ? 1 : 0));
      chk("done", 32'(done), 32'((m_state == 3) ? 1 : 0));
      if (m_rd_known) chk("readdata", avs_readdata, m_rd);
    end
    while (lit_exp_q.size() > 0) begin
      chk(lit_name_q.pop_front(), avs_readdata, lit_exp_q.pop_front());
    end
    model_step();
  end

  task automatic tick();
    @(posedge div_clock);
    #1;
    ramp_v++;
    data_in = 32'(ramp_v);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd_expect(input logic [1:0] a, input logic [31:0] exp, input string nm);
    avs_read = 1'b1; avs_address = a;
    tick();
    avs_read = 1'b0;
    lit_exp_q.push_back(exp);
    lit_name_q.push_back(nm);
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset values
    rd_expect(2'd0, 32'h0, "reset_ctrl");
    rd_expect(2'd1, 32'd0, "reset_count");

    // Trigger before arm is ignored
    pulse_trigger();
    rd_expect(2'd1, 32'd0, "trig_before_arm_count");
    rd_expect(2'd0, 32'h0, "trig_before_arm_ctrl");

    // Arm, ramp, trigger on value 5, full capture
    wr(2'd0, 32'h1);
    rd_expect(2'd0, 32'h5, "armed_ctrl");
    ramp_v = 0; data_in = 32'd0;
    repeat (5) tick();
    pulse_trigger();
    repeat (256) tick();
    rd_expect(2'd0, 32'hE, "done_ctrl");
    rd_expect(2'd1, 32'd256, "done_count");

    // Back-to-back DATA reads of the whole buffer
    avs_read = 1'b1; avs_address = 2'd3;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      lit_exp_q.push_back(32'(5 + i));
      lit_name_q.push_back("data_ramp");
    end
    avs_read = 1'b0;

    // Pointer write with junk upper bits, then wrap
    wr(2'd2, 32'hABCD_12FF);
    rd_expect(2'd3, 32'd260, "data_entry255");
    rd_expect(2'd3, 32'd5, "data_wrap_entry0");
    rd_expect(2'd2, 32'd1, "rdptr_after_wrap");

    // Re-arm from DONE, clear at capture cycle 100
    wr(2'd0, 32'h1);
    rd_expect(2'd2, 32'd0, "rearm_rdptr");
    pulse_trigger();
    repeat (99) tick();
    wr(2'd0, 32'h2);
    rd_expect(2'd0, 32'h0, "clear_ctrl");
    rd_expect(2'd1, 32'd0, "clear_count");
    pulse_trigger();
    rd_expect(2'd1, 32'd0, "clear_trig_ignored");

    // Clear wins over arm in the same write
    wr(2'd0, 32'h1);
    rd_expect(2'd0, 32'h5, "arm_again_ctrl");
    wr(2'd0, 32'h3);
    rd_expect(2'd0, 32'h0, "clear_wins_ctrl");

    // Reset in the middle of a capture at count 40
    wr(2'd0, 32'h1);
    pulse_trigger();
    repeat (38) tick();
    rd_expect(2'd1, 32'd39, "midcap_count");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    rd_expect(2'd0, 32'h0, "post_reset_ctrl");
    rd_expect(2'd1, 32'd0, "post_reset_count");

    // Randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      reset_n       = ($urandom_range(0, 399) != 0);
      trigger       = ($urandom_range(0, 7) == 0);
      avs_read      = $urandom_range(0, 1) == 1;
      avs_address   = 2'($urandom_range(0, 3));
      avs_write     = ($urandom_range(0, 15) == 0);
      avs_writedata = (avs_address == 2'd0) ? 32'($urandom_range(0, 3)) : $urandom;
      @(posedge div_clock);
      #1;
      data_in = $urandom;
    end
    reset_n = 1'b1; trigger = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
